// File: rtl/ring_serial_tx.sv
// ring_serial_tx: parallel-to-serial transmitter, MSB first, with optional
// continuous recirculation (ring mode) ended by stop at a pass boundary.
`default_nettype none

module ring_serial_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ring_mode,
  input  logic             stop,
  input  logic             abort,
  output logic             d_out,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             stop_pending;
  logic             ring_l;
  logic             done_r;
  logic             done_nxt;

  logic accept;
  logic last_bit;
  logic keep_ringing;

  assign accept       = (state == IDLE) && load_valid && !abort;
  assign last_bit     = (cnt == LAST);
  assign keep_ringing = ring_l && !stop_pending && !stop;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        // abort wins over both the pass-boundary decision and stop
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_bit && !keep_ringing) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    busy        = 1'b0;
    d_out       = 1'b0;
    frame_start = 1'b0;
    done        = done_r;
    case (state)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        busy        = 1'b1;
        d_out       = shreg[WIDTH-1];
        frame_start = (cnt == '0);
      end
      default: load_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg        <= '0;
      cnt          <= '0;
      stop_pending <= 1'b0;
      ring_l       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= done_nxt;
      if (state == IDLE) begin
        if (accept) begin
          shreg        <= load_data;
          cnt          <= '0;
          ring_l       <= ring_mode;
          stop_pending <= 1'b0;
        end
      end else if (abort) begin
        shreg        <= '0;
        cnt          <= '0;
        stop_pending <= 1'b0;
      end else begin
        // rotate rather than shift so the word survives for the next pass
        shreg <= {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        cnt   <= last_bit ? '0 : cnt + 1'b1;
        if (stop) stop_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ring_serial_tx.sv
// Directed bench for ring_serial_tx; per-cycle expectations are hand-derived
// and compared as {d_out, frame_start, busy, done, load_ready}.
`default_nettype none

module tb_ring_serial_tx;

  logic       clk;
  logic       clr_n;
  logic [3:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       ring_mode;
  logic       stop;
  logic       abort;
  logic       d_out;
  logic       frame_start;
  logic       busy;
  logic       done;

  int vectors;
  int errors;

  ring_serial_tx #(.WIDTH(4)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .ring_mode   (ring_mode),
    .stop        (stop),
    .abort       (abort),
    .d_out       (d_out),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and let it be accepted; returns inside C1.
  task automatic start_word(input logic [3:0] data, input logic ring);
    load_data  = data;
    ring_mode  = ring;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    clr_n = 1'b0;
    step();
    @(negedge clk);
    obs = {d_out, frame_start, busy, done, load_ready};
    vectors++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL reset_initial: got %b expected %b", obs, 5'b00001);
    end
    @(negedge clk);
    clr_n = 1'b1;
    step();
    // Reset asserted mid-SHIFT must clear outputs without waiting for a clock.
    start_word(4'b1011, 1'b0);
    step();
    clr_n = 1'b0;
    #1;
    obs = {d_out, frame_start, busy, done, load_ready};
    vectors++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs, 5'b00001);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL reset_release_c%0d: got %b expected %b", k, obs, 5'b00001);
      end
    end
    step();
  endtask

  task automatic test_single_word();
    logic [4:0] exp_v [1:6];
    logic [4:0] obs;
    exp_v[1] = 5'b11100;
    exp_v[2] = 5'b00100;
    exp_v[3] = 5'b10100;
    exp_v[4] = 5'b10100;
    exp_v[5] = 5'b00011;
    exp_v[6] = 5'b00001;
    start_word(4'b1011, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) load_data = 4'b0000;
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL single_c%0d: got %b expected %b", k, obs, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v [1:11];
    logic [4:0] obs;
    exp_v[1]  = 5'b11100;
    exp_v[2]  = 5'b00100;
    exp_v[3]  = 5'b10100;
    exp_v[4]  = 5'b10100;
    exp_v[5]  = 5'b00011;
    exp_v[6]  = 5'b01100;
    exp_v[7]  = 5'b10100;
    exp_v[8]  = 5'b10100;
    exp_v[9]  = 5'b00100;
    exp_v[10] = 5'b00011;
    exp_v[11] = 5'b00001;
    start_word(4'b1011, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) begin
        load_data  = 4'b0110;
        load_valid = 1'b1;
      end
      if (k == 6) load_valid = 1'b0;
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_c%0d: got %b expected %b", k, obs, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_ring();
    logic [4:0] exp_v [1:10];
    logic [4:0] obs;
    exp_v[1]  = 5'b11100;
    exp_v[2]  = 5'b00100;
    exp_v[3]  = 5'b00100;
    exp_v[4]  = 5'b00100;
    exp_v[5]  = 5'b11100;
    exp_v[6]  = 5'b00100;
    exp_v[7]  = 5'b00100;
    exp_v[8]  = 5'b00100;
    exp_v[9]  = 5'b00011;
    exp_v[10] = 5'b00001;
    start_word(4'b1000, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) ring_mode = 1'b0;   // latched at accept, must not matter now
      if (k == 6) stop = 1'b1;
      if (k == 7) stop = 1'b0;
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL ring_c%0d: got %b expected %b", k, obs, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_stop_boundary();
    logic [4:0] exp_v [1:6];
    logic [4:0] obs;
    exp_v[1] = 5'b11100;
    exp_v[2] = 5'b10100;
    exp_v[3] = 5'b00100;
    exp_v[4] = 5'b00100;
    exp_v[5] = 5'b00011;
    exp_v[6] = 5'b00001;
    start_word(4'b1100, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) stop = 1'b1;
      if (k == 5) stop = 1'b1;        // stop in IDLE is ignored
      if (k == 6) stop = 1'b0;
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL stop_boundary_c%0d: got %b expected %b", k, obs, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp_v [1:6];
    logic [4:0] obs;
    exp_v[1] = 5'b11100;
    exp_v[2] = 5'b10100;
    exp_v[3] = 5'b00001;
    exp_v[4] = 5'b00001;
    exp_v[5] = 5'b00001;
    exp_v[6] = 5'b00001;
    start_word(4'b1111, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin
        abort = 1'b1;
        stop  = 1'b1;
      end
      if (k == 3) begin
        stop       = 1'b0;
        load_data  = 4'b1010;
        load_valid = 1'b1;            // held with abort: must not be accepted
      end
      if (k == 4) begin
        abort      = 1'b0;
        load_valid = 1'b0;
      end
      @(negedge clk);
      obs = {d_out, frame_start, busy, done, load_ready};
      vectors++;
      if (obs !== exp_v[k]) begin
        errors++;
        $display("FAIL abort_c%0d: got %b expected %b", k, obs, exp_v[k]);
      end
      step();
    end
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    clr_n      = 1'b0;
    load_data  = 4'b0000;
    load_valid = 1'b0;
    ring_mode  = 1'b0;
    stop       = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ring();
    test_stop_boundary();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ring_serial_tx.md
Name: ring_serial_tx

Overview:
- Parallel-to-serial transmitter that produces the serial bit stream consumed by the 4-bit ring counter / serial shift chain.
- Accepts a WIDTH-bit word over a valid/ready load interface and shifts it out MSB-first on d_out, one bit per clock.
- In ring mode it recirculates the word continuously, acting as a ring-pattern generator, until told to stop.
- Sits upstream of the ring-counter datapath and replaces hand-driven d_in sequences in benches and at system level.

Parameters:
- WIDTH, 4, bits per word/pass; legal range 2..16.
- CW, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- load_data  input  WIDTH  word to transmit.
- load_valid  input  1  load_data valid.
- load_ready  output  1  block can accept a word.
- ring_mode  input  1  recirculate the word; sampled only at accept.
- stop  input  1  end ring transmission at the next pass boundary.
- abort  input  1  synchronous immediate cancel.
- d_out  output  1  serial data, MSB first.
- frame_start  output  1  high while d_out carries bit WIDTH-1 of a pass.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after normal completion.

Behaviour:
- Interface decision: one clock, clk; reset clr_n is asynchronous, active-low. While clr_n=0:
  - state=IDLE; shreg, cnt, stop_pending, ring_l all cleared.
  - load_ready=1; d_out=0; frame_start=0; busy=0; done=0.
- States are IDLE and SHIFT.
- IDLE:
  - load_ready=1, busy=0, d_out=0, frame_start=0.
  - stop is ignored in IDLE.
  - Accept = load_valid & load_ready at a rising edge (E0). On accept: shreg<=load_data, cnt<=0, ring_l<=ring_mode, stop_pending<=0, state<=SHIFT.
- SHIFT:
  - load_ready=0, busy=1.
  - d_out=shreg[WIDTH-1]; frame_start=(cnt==0). Both are decoded from flops only, with no combinational path from inputs.
  - Each edge: shreg rotates left, {shreg[WIDTH-2:0],shreg[WIDTH-1]}, so the word is preserved after WIDTH shifts.
  - Each edge: cnt increments.
  - stop=1 in any SHIFT cycle sets stop_pending. This includes the last bit cycle of a pass, which makes that pass the final one.
- Pass boundary, i.e. the edge where cnt==WIDTH-1:
  - If ring_l=1 and stop_pending=0 and stop=0: cnt<=0 and shifting continues with no gap.
  - Otherwise: state<=IDLE and done<=1 for exactly one cycle.
- Timing:
  - Bit k (MSB=k0) appears on d_out in cycle C(k+1) after E0.
  - Non-ring latency: WIDTH cycles of data; done is high in cycle C(WIDTH+1).
  - load_ready is also high in the done cycle, so a back-to-back load accepted there starts on the next edge. Minimum inter-word gap is one cycle.
- abort:
  - abort=1 in SHIFT: next edge goes to IDLE and clears shreg, cnt and stop_pending. done is not pulsed.
  - abort takes priority over the boundary logic and over stop.
  - abort=1 in IDLE blocks accept in that cycle.
- Simultaneous events:
  - load_valid with abort in IDLE: abort wins, no accept.
  - stop with abort: abort wins.
- Reset mid-operation: outputs go to their reset values immediately and asynchronously. Any partial word is discarded.
- ring_mode or load_data changing during SHIFT has no effect.

Test Plan:
- Reset: hold clr_n=0 for 3 cycles mid-SHIFT, then release → d_out=0, busy=0, load_ready=1, done=0 immediately on clr_n fall; idle after release.
- Single word, ring_mode=0, load_data=4'b1011 → d_out=1,0,1,1 in C1–C4; frame_start only in C1; busy C1–C4; done=1 only in C5.
- Back-to-back: 4'b1011, then 4'b0110 presented in the done cycle → d_out=1,0,1,1 in C1–C4, 0 in C5, then 0,1,1,0 in C6–C9; second done in C10.
- Ring: 4'b1000, ring_mode=1, stop pulsed in C6 → d_out=1,0,0,0,1,0,0,0; frame_start in C1 and C5; done in C9.
- Stop at the boundary: ring 4'b1100 with stop pulsed in C4 → exactly one pass (1,1,0,0); done in C5.
- Abort: 4'b1111 with abort in C2 → IDLE from C3 with d_out=0 and busy=0; done never asserts; a load_valid held with abort in IDLE is not accepted.
